// File: rtl/bcd_scan4.sv
// bcd_scan4: four-digit common-anode seven-segment scan driver.
// Latches four BCD digits and decimal points on a load strobe. It shows one
// digit at a time, for REFRESH_DIV clocks per digit. All outputs are active-low.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
//
// state (idx) | meaning
// 0           | digit 0 (ones) on an[0]
// 1           | digit 1 (tens) on an[1]
// 2           | digit 2 (hundreds) on an[2]
// 3           | digit 3 (thousands) on an[3]
module bcd_scan4 #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] dp_in,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       scan_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic          tick_q;
  logic [1:0]    idx;
  logic [3:0]    dig [4];
  logic [3:0]    dpr;
  logic [6:0]    seg_cur;
  logic [3:0]    blank;

  assign tick = (pre_cnt == DIV_LAST);

  // Prescaler: counts 0..REFRESH_DIV-1; tick marks the last count of a slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  // Digit ring: idx advances on tick and wraps 3 -> 0 naturally in 2 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    idx <= 2'd0;
    else if (tick) idx <= idx + 2'd1;
  end

  // scan_tick is delayed two edges so it lines up with the new anode on the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q    <= 1'b0;
      scan_tick <= 1'b0;
    end else begin
      tick_q    <= tick;
      scan_tick <= tick_q;
    end
  end

  // Holding registers capture the digits and decimal points on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig[0] <= 4'd0;
      dig[1] <= 4'd0;
      dig[2] <= 4'd0;
      dig[3] <= 4'd0;
      dpr    <= 4'd0;
    end else if (load) begin
      dig[0] <= d0;
      dig[1] <= d1;
      dig[2] <= d2;
      dig[3] <= d3;
      dpr    <= dp_in;
    end
  end

  // Active-low gfedcba decode of the selected digit; non-BCD codes show a dash.
  always_comb begin
    seg_cur = 7'b0111111;
    case (dig[idx])
      4'd0: seg_cur = 7'b1000000;
      4'd1: seg_cur = 7'b1111001;
      4'd2: seg_cur = 7'b0100100;
      4'd3: seg_cur = 7'b0110000;
      4'd4: seg_cur = 7'b0011001;
      4'd5: seg_cur = 7'b0010010;
      4'd6: seg_cur = 7'b0000010;
      4'd7: seg_cur = 7'b1111000;
      4'd8: seg_cur = 7'b0000000;
      4'd9: seg_cur = 7'b0010000;
      default: seg_cur = 7'b0111111;
    endcase
  end

  // Blank mask: a digit goes dark only if it and every digit above are zero
  // with no decimal point lit. Digit 0 always shows.
  always_comb begin
    blank = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    blank[3] = (dig[3] == 4'd0) && !dpr[3];
    blank[2] = blank[3] && (dig[2] == 4'd0) && !dpr[2];
    blank[1] = blank[2] && (dig[1] == 4'd0) && !dpr[1];
`endif
  end

  // Output registers refresh every cycle so a load appears on the pins without waiting for a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else if (blank[idx]) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= seg_cur;
      dp  <= ~dpr[idx];
    end
  end

endmodule

// File: doc/bcd_scan4.md
# bcd_scan4

Four-digit seven-segment scan driver sitting directly downstream of the binary-to-BCD converter. It latches four BCD digits on a load strobe, decodes them to active-low segment patterns, and time-multiplexes them onto a common-anode display. A programmable prescaler sets the per-digit refresh rate. Typical use: the converter's ones/tens feed d0/d1, and d2/d3 come from a second converter.

## Interface
- REFRESH_DIV, 100000: clk cycles each digit is shown (1 kHz per digit at 100 MHz); legal range 1..2^20.
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- load  input  1  single-cycle strobe; captures d0..d3 and dp_in
- d0  input  4  BCD digit, rightmost (ones)
- d1  input  4  BCD digit (tens)
- d2  input  4  BCD digit (hundreds)
- d3  input  4  BCD digit, leftmost (thousands)
- dp_in  input  4  decimal point per digit, bit i = digit i, 1 = lit
- an  output  4  digit anodes, active-low, an[i] = digit i
- seg  output  7  segments, active-low, seg[0]=a … seg[6]=g
- dp  output  1  decimal point, active-low
- scan_tick  output  1  one-cycle pulse when the digit index advances

## Operation
- Holding registers: dig[0..3] and dpr[3:0] load from the inputs on a clk edge where load=1; otherwise hold. Reset value 0.
- Prescaler: counter 0..REFRESH_DIV-1, width $clog2(REFRESH_DIV) (min 1). At REFRESH_DIV-1 it wraps to 0 and asserts an internal tick. REFRESH_DIV=1 means a tick every cycle.
- Digit index idx (2 bits): increments on tick, wraps 3→0. Reset 0.
- Decode of dig[idx] (active-low, gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Codes 10–15 (invalid BCD) show a dash: 0111111.
- Output registers an, seg, dp update every clk cycle from the current idx and holding registers (not only on tick). an = one-hot-low on idx; dp = ~dpr[idx].
- No state beyond prescaler, idx, holding registers and output registers; no FSM states other than the 4-state idx ring.

## Timing
- Reset (async assert, sync-release is the system's responsibility): an=1111, seg=1111111, dp=1, scan_tick=0, idx=0, prescaler=0, holding regs=0.
- First output edge after reset release: an=1110, seg=1000000 (digit 0 showing "0").
- load at edge N → holding regs updated at edge N; visible on seg/dp at edge N+1 if that digit is active (2-cycle strobe-to-pin latency).
- Tick at edge T advances idx at T; an/seg reflect the new digit at T+1. scan_tick is registered and is high during the cycle after edge T+1, aligned with the new an.
- load coincident with tick: both take effect at the same edge; the next output update uses new idx and new data.
- Each digit is active exactly REFRESH_DIV cycles; full frame = 4·REFRESH_DIV cycles.
- an and seg change on the same edge; never two anodes low at once.
- Reset asserted mid-scan: all outputs go to reset values immediately, without waiting for a clock.

## Configuration
- LEADING_ZERO_BLANK_EN defined: digit i (i=3,2,1) is blanked (an[i] held high, seg=1111111, dp=1 for its slot) when dig[i]=0 and every higher digit is 0 and dpr for digits ≥ i is 0. Digit 0 is never blanked. Slot timing is unchanged (blanked slot still lasts REFRESH_DIV cycles).
- Not defined: all four digits are always driven, zeros shown as "0".

## Test plan
- Reset: hold rst_n=0 with clock running → an=1111, seg=1111111, dp=1, scan_tick=0; release → next edge an=1110, seg=1000000.
- REFRESH_DIV=4, load d3..d0=1,2,3,4, dp_in=0010 → repeating sequence every 4 cycles: an=1110/seg=0011001, an=1101/seg=0110000/dp=0, an=1011/seg=0100100, an=0111/seg=1111001; scan_tick once per slot.
- Load d0=4'hC → digit 0 slot shows seg=0111111 (dash).
- Load new data mid-slot on the active digit → seg changes exactly 2 cycles after load, an unchanged, idx cadence undisturbed.
- With LEADING_ZERO_BLANK_EN, load 0,0,0,7 (d3..d0) → slots 1–3 an=1111, seg=1111111; slot 0 shows 7 (1111000); load 0,0,0,0 → only digit 0 lit showing "0". Without macro, the same loads show all four digits.
- Assert rst_n low during slot 2 for less than a clock period → outputs reset asynchronously; after release, scan restarts at digit 0 with holding regs cleared.
